// File: rtl/lookup_stage.sv
// lookup_stage: one level of a pipelined binary-tree lookup.
// A lookup reads its node in the first cycle and branches on key >= pivot in the
// second. A small update FSM writes new node words through a separate port.
module lookup_stage #(
   parameter int STAGE_ID = 0,
   parameter int KEY      = 32,
   parameter int RESULT   = 16,
   parameter int ADDR     = 10,
   parameter int DATA     = 72
) (
   input  logic              clk,
   input  logic              rst,
   // lookup from the upstream stage
   input  logic              in_valid,
   input  logic [KEY-1:0]    in_key,
   input  logic [ADDR-1:0]   in_addr,
   input  logic [RESULT-1:0] in_result,
   input  logic              in_result_valid,
   // lookup to the downstream stage
   output logic              out_valid,
   output logic [KEY-1:0]    out_key,
   output logic [ADDR-1:0]   out_addr,
   output logic [RESULT-1:0] out_result,
   output logic              out_result_valid,
   // node memory read port (1-cycle latency)
   output logic [ADDR-1:0]   mem_addr,
   input  logic [DATA-1:0]   mem_dout,
   // node memory write port
   output logic              mem_wr,
   output logic [ADDR-1:0]   mem_wr_addr,
   output logic [DATA-1:0]   mem_din,
   // table update handshake
   input  logic              upd_valid,
   input  logic [ADDR-1:0]   upd_addr,
   input  logic [DATA-1:0]   upd_data,
   output logic              upd_ready,
   output logic [31:0]       lookup_count
);

   // Node word layout, MSB first: pivot, result, child_base, result_flag, pad.
   localparam int PIV_LSB   = DATA - KEY;
   localparam int RES_LSB   = PIV_LSB - RESULT;
   localparam int CHILD_LSB = RES_LSB - ADDR;
   localparam int FLAG_POS  = CHILD_LSB - 1;

   generate
      if ((DATA < KEY + RESULT + ADDR + 1) || (STAGE_ID < 0)) begin : g_param_check
         $fatal(1, "lookup_stage %0d: DATA too narrow for node fields", STAGE_ID);
      end
      if (FLAG_POS > 0) begin : g_pad
         logic unused_pad_s;
         assign unused_pad_s = ^mem_dout[FLAG_POS-1:0];
      end
   endgenerate

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } upd_state_t;

   logic              s1_valid_r;
   logic [KEY-1:0]    s1_key_r;
   logic [RESULT-1:0] s1_result_r;
   logic              s1_result_valid_r;

   logic [KEY-1:0]    pivot_s;
   logic [RESULT-1:0] node_result_s;
   logic [ADDR-1:0]   child_base_s;
   logic              result_flag_s;
   logic              ge_s;
   logic              hit_s;

   logic              out_valid_r;
   logic [KEY-1:0]    out_key_r;
   logic [ADDR-1:0]   out_addr_r;
   logic [RESULT-1:0] out_result_r;
   logic              out_result_valid_r;
   logic [31:0]       lookup_count_r;

   upd_state_t        state_r;
   logic              mem_wr_r;
   logic [ADDR-1:0]   mem_wr_addr_r;
   logic [DATA-1:0]   mem_din_r;
   logic              upd_ready_s;

   // The read address follows the incoming lookup directly so the node
   // word arrives exactly when the stage-1 registers hold the lookup.
   assign mem_addr = in_addr;

   assign pivot_s       = mem_dout[DATA-1 -: KEY];
   assign node_result_s = mem_dout[PIV_LSB-1 -: RESULT];
   assign child_base_s  = mem_dout[RES_LSB-1 -: ADDR];
   assign result_flag_s = mem_dout[FLAG_POS];
   assign ge_s          = (s1_key_r >= pivot_s);
   assign hit_s         = ge_s & result_flag_s;

   // Stage 1: hold the lookup while its node word is being read.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r        <= 1'b0;
         s1_key_r          <= '0;
         s1_result_r       <= '0;
         s1_result_valid_r <= 1'b0;
      end else begin
         s1_valid_r        <= in_valid;
         s1_key_r          <= in_key;
         s1_result_r       <= in_result;
         s1_result_valid_r <= in_result_valid;
      end
   end

   // Stage 2: branch on the pivot and register the downstream lookup;
   // outputs hold their last values on idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r        <= 1'b0;
         out_key_r          <= '0;
         out_addr_r         <= '0;
         out_result_r       <= '0;
         out_result_valid_r <= 1'b0;
      end else if (s1_valid_r) begin
         out_valid_r        <= 1'b1;
         out_key_r          <= s1_key_r;
         // child_base*2 + ge, upper bit dropped on wrap
         out_addr_r         <= ADDR'({child_base_s, ge_s});
         out_result_r       <= hit_s ? node_result_s : s1_result_r;
         out_result_valid_r <= hit_s ? 1'b1 : s1_result_valid_r;
      end else begin
         out_valid_r        <= 1'b0;
      end
   end

   // Completed-lookup counter, saturating at all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         lookup_count_r <= 32'd0;
      end else if (out_valid_r && (lookup_count_r != 32'hFFFF_FFFF)) begin
         lookup_count_r <= lookup_count_r + 32'd1;
      end else begin
         lookup_count_r <= lookup_count_r;
      end
   end

   // Update FSM: capture one update in IDLE, drive a single write pulse in WRITE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         mem_wr_r      <= 1'b0;
         mem_wr_addr_r <= '0;
         mem_din_r     <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (upd_valid && upd_ready_s) begin
                  state_r       <= ST_WRITE;
                  mem_wr_r      <= 1'b1;
                  mem_wr_addr_r <= upd_addr;
                  mem_din_r     <= upd_data;
               end else begin
                  state_r  <= ST_IDLE;
                  mem_wr_r <= 1'b0;
               end
            end
            ST_WRITE: begin
               state_r  <= ST_IDLE;
               mem_wr_r <= 1'b0;
            end
            default: begin
               state_r  <= ST_IDLE;
               mem_wr_r <= 1'b0;
            end
         endcase
      end
   end

   // Reset masks the handshake and any write that was about to land, so an
   // update in flight at reset never reaches the memory.
   assign upd_ready_s = (state_r == ST_IDLE) && !rst;
   assign upd_ready   = upd_ready_s;
   assign mem_wr      = mem_wr_r && !rst;
   assign mem_wr_addr = mem_wr_addr_r;
   assign mem_din     = mem_din_r;

   assign out_valid        = out_valid_r;
   assign out_key          = out_key_r;
   assign out_addr         = out_addr_r;
   assign out_result       = out_result_r;
   assign out_result_valid = out_result_valid_r;
   assign lookup_count     = lookup_count_r;

endmodule

// File: tb/tb_lookup_stage.sv
// Directed bench for lookup_stage with a read-first node memory model.
module tb_lookup_stage;

   localparam int KEY    = 32;
   localparam int RESULT = 16;
   localparam int ADDR   = 10;
   localparam int DATA   = 72;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [KEY-1:0]    in_key;
   logic [ADDR-1:0]   in_addr;
   logic [RESULT-1:0] in_result;
   logic              in_result_valid;
   logic              out_valid;
   logic [KEY-1:0]    out_key;
   logic [ADDR-1:0]   out_addr;
   logic [RESULT-1:0] out_result;
   logic              out_result_valid;
   logic [ADDR-1:0]   mem_addr;
   logic [DATA-1:0]   mem_dout;
   logic              mem_wr;
   logic [ADDR-1:0]   mem_wr_addr;
   logic [DATA-1:0]   mem_din;
   logic              upd_valid;
   logic [ADDR-1:0]   upd_addr;
   logic [DATA-1:0]   upd_data;
   logic              upd_ready;
   logic [31:0]       lookup_count;

   int n_cmp  = 0;
   int n_fail = 0;
   int wr_pulses;

   logic [DATA-1:0] mem_model [0:(1<<ADDR)-1];

   always #5 clk = ~clk;

   lookup_stage #(.STAGE_ID(0), .KEY(KEY), .RESULT(RESULT), .ADDR(ADDR), .DATA(DATA)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_key(in_key), .in_addr(in_addr),
      .in_result(in_result), .in_result_valid(in_result_valid),
      .out_valid(out_valid), .out_key(out_key), .out_addr(out_addr),
      .out_result(out_result), .out_result_valid(out_result_valid),
      .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_din(mem_din),
      .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
      .upd_ready(upd_ready), .lookup_count(lookup_count)
   );

   // Dual-port node memory: read-first, 1-cycle read latency.
   always @(posedge clk) begin
      mem_dout <= mem_model[mem_addr];
      if (mem_wr) mem_model[mem_wr_addr] <= mem_din;
   end

   function automatic logic [DATA-1:0] node(input logic [KEY-1:0] pivot, input logic [RESULT-1:0] res,
                                            input logic [ADDR-1:0] child, input logic flag);
      node = {pivot, res, child, flag, {(DATA-KEY-RESULT-ADDR-1){1'b0}}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_update(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
      upd_valid = 1'b1;
      upd_addr  = a;
      upd_data  = d;
      #1;
      check("upd_ready_idle", upd_ready, 1);
      tick();
      upd_valid = 1'b0;
      check("upd_wr_pulse", mem_wr, 1);
      check("upd_wr_addr", mem_wr_addr, a);
      check("upd_wr_data", mem_din, d);
      check("upd_ready_write", upd_ready, 0);
      tick();
      check("upd_wr_end", mem_wr, 0);
   endtask

   task automatic lookup(input string tag, input logic [KEY-1:0] k, input logic [ADDR-1:0] a,
                         input logic [RESULT-1:0] r, input logic rv,
                         input logic [ADDR-1:0] ea, input logic [RESULT-1:0] er, input logic erv);
      in_valid = 1'b1; in_key = k; in_addr = a; in_result = r; in_result_valid = rv;
      #1;
      check({tag, "_mem_addr"}, mem_addr, a);
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1"}, out_valid, 0);
      tick();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_key"}, out_key, k);
      check({tag, "_addr"}, out_addr, ea);
      check({tag, "_result"}, out_result, er);
      check({tag, "_rvalid"}, out_result_valid, erv);
   endtask

   logic [DATA-1:0]   node_a, node_b;
   logic              ev  [0:17];
   logic [KEY-1:0]    ek  [0:17];
   logic [ADDR-1:0]   ea  [0:17];
   logic [RESULT-1:0] er  [0:17];
   logic              erv [0:17];

   initial begin
      int v;
      logic ge;
      logic [KEY-1:0] k;
      logic [RESULT-1:0] r;
      rst = 1'b1; in_valid = 1'b0; in_key = '0; in_addr = '0; in_result = '0;
      in_result_valid = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_data = '0;
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_key", out_key, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_rvalid", out_result_valid, 0);
      check("rst_count", lookup_count, 0);
      check("rst_mem_wr", mem_wr, 0);
      check("rst_upd_ready", upd_ready, 0);
      rst = 1'b0;
      #1;
      check("post_rst_ready", upd_ready, 1);

      // Load nodes through the update port.
      do_update(10'd5,  node(32'h100, 16'h00AA, 10'd3,   1'b1));
      do_update(10'd9,  node(32'h050, 16'h1234, 10'h3FF, 1'b1));
      do_update(10'd12, node(32'h080, 16'h0BEE, 10'h010, 1'b0));

      lookup("ge_hit",   32'h100,       10'd5,  16'h0000, 1'b0, 10'd7,   16'h00AA, 1'b1);
      tick();
      check("idle_valid", out_valid, 0);
      check("idle_hold_addr", out_addr, 7);
      check("idle_hold_key", out_key, 32'h100);
      lookup("lt_pass",  32'h0FF,       10'd5,  16'h0011, 1'b1, 10'd6,   16'h0011, 1'b1);
      lookup("wrap",     32'h060,       10'd9,  16'h0000, 1'b0, 10'h3FF, 16'h1234, 1'b1);
      lookup("unsigned", 32'hFFFF_FFFF, 10'd5,  16'h0001, 1'b0, 10'd7,   16'h00AA, 1'b1);
      lookup("noflag",   32'h090,       10'd12, 16'h2222, 1'b0, 10'h021, 16'h2222, 1'b0);

      // Burst: ten back-to-back lookups then three gapped ones, from a clean count.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("burst_count0", lookup_count, 0);
      v = 0;
      for (int c = 0; c < 18; c++) begin
         if (c < 10 || c == 11 || c == 13 || c == 15) begin
            k = 32'h0C0 + 32'(v) * 32'h20;
            r = 16'h0100 + 16'(v);
            ge = (k >= 32'h100);
            in_valid = 1'b1; in_key = k; in_addr = 10'd5; in_result = r; in_result_valid = v[0];
            ev[c] = 1'b1; ek[c] = k; ea[c] = ge ? 10'd7 : 10'd6;
            er[c] = ge ? 16'h00AA : r; erv[c] = ge ? 1'b1 : v[0];
            v++;
         end else begin
            in_valid = 1'b0;
            ev[c] = 1'b0; ek[c] = '0; ea[c] = '0; er[c] = '0; erv[c] = 1'b0;
         end
         tick();
         if (c >= 1) begin
            check($sformatf("burst_valid_%0d", c), out_valid, ev[c-1]);
            if (ev[c-1]) begin
               check($sformatf("burst_key_%0d", c), out_key, ek[c-1]);
               check($sformatf("burst_addr_%0d", c), out_addr, ea[c-1]);
               check($sformatf("burst_res_%0d", c), out_result, er[c-1]);
               check($sformatf("burst_rv_%0d", c), out_result_valid, erv[c-1]);
            end
         end
      end
      in_valid = 1'b0;
      tick();
      check("burst_count13", lookup_count, 13);

      // upd_valid held four cycles; a lookup in the first write cycle sees the old node.
      node_a = node(32'h200, 16'h00BB, 10'd1, 1'b1);
      node_b = node(32'h010, 16'h0CCC, 10'd2, 1'b1);
      wr_pulses = 0;
      upd_valid = 1'b1; upd_addr = 10'd5; upd_data = node_a;
      #1;
      check("hold_rdy0", upd_ready, 1);
      wr_pulses += int'(mem_wr);
      tick();
      check("hold_rdy1", upd_ready, 0);
      wr_pulses += int'(mem_wr);
      in_valid = 1'b1; in_addr = 10'd5; in_key = 32'h100; in_result = 16'h0055; in_result_valid = 1'b0;
      upd_addr = 10'd20; upd_data = node_b;
      tick();
      in_valid = 1'b0;
      check("hold_rdy2", upd_ready, 1);
      wr_pulses += int'(mem_wr);
      tick();
      check("hold_rdy3", upd_ready, 0);
      wr_pulses += int'(mem_wr);
      check("rf_valid", out_valid, 1);
      check("rf_addr_old", out_addr, 7);
      check("rf_result_old", out_result, 16'h00AA);
      upd_valid = 1'b0;
      tick();
      wr_pulses += int'(mem_wr);
      check("hold_rdy_after", upd_ready, 1);
      check("hold_wr_pulses", wr_pulses, 2);
      lookup("new_a", 32'h100, 10'd5,  16'h0055, 1'b0, 10'd2, 16'h0055, 1'b0);
      lookup("new_b", 32'h010, 10'd20, 16'h0000, 1'b0, 10'd5, 16'h0CCC, 1'b1);

      // Reset one cycle after a lookup and during a WRITE cycle.
      in_valid = 1'b1; in_key = 32'h300; in_addr = 10'd5; in_result = 16'h0000; in_result_valid = 1'b0;
      upd_valid = 1'b1; upd_addr = 10'd5; upd_data = node_b;
      tick();
      in_valid = 1'b0; upd_valid = 1'b0; rst = 1'b1;
      #1;
      check("rst_write_mem_wr", mem_wr, 0);
      check("rst_write_ready", upd_ready, 0);
      tick();
      check("rst2_out_valid", out_valid, 0);
      check("rst2_out_key", out_key, 0);
      check("rst2_out_addr", out_addr, 0);
      check("rst2_out_result", out_result, 0);
      check("rst2_out_rvalid", out_result_valid, 0);
      check("rst2_count", lookup_count, 0);
      check("rst2_mem_wr", mem_wr, 0);
      rst = 1'b0;
      tick();
      check("rst2_discard_valid", out_valid, 0);
      check("rst2_discard_wr", mem_wr, 0);
      lookup("after_rst", 32'h300, 10'd5, 16'h0000, 1'b0, 10'd3, 16'h00BB, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
